// File: rtl/sys_defs.sv
// Shared fetch-side types: bus commands, memory tags and
// the instruction-buffer row packet.
package sys_defs;

  typedef logic [3:0] MEM_TAG;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic [31:0] PC;
  } IF_IB_PACKET;

  typedef struct packed {
    MEM_TAG      tag;
    logic [31:0] pc;
    logic        stale;
  } FETCH_PENDING_ENTRY;

endpackage

// File: rtl/fetch_pending_q.sv
// Circular queue of outstanding fetch transactions.
// All entries can be marked stale at once on a flush.
import sys_defs::*;

module fetch_pending_q #(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push_i,
  input  FETCH_PENDING_ENTRY push_entry_i,
  input  logic               pop_i,
  input  logic               mark_all_stale_i,
  output FETCH_PENDING_ENTRY head_o,
  output logic               full_o,
  output logic               empty_o
);

  FETCH_PENDING_ENTRY mem_q [DEPTH];
  logic [PW-1:0]      head_q;
  logic [PW-1:0]      tail_q;
  logic [CW-1:0]      count_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_o  = mem_q[head_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (mark_all_stale_i)
        for (int i = 0; i < DEPTH; i++) mem_q[i].stale <= 1'b1;
      if (push_i) begin
        mem_q[tail_q] <= push_entry_i;
        tail_q        <= wrap_inc(tail_q);
      end
      if (pop_i) head_q <= wrap_inc(head_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/ib_fetch_ctrl.sv
// Fetch sequencer: issues 64-bit imem loads under a credit
// limit and writes two-instruction rows to the inst buffer.
import sys_defs::*;

module ib_fetch_ctrl #(
  parameter int          IB_DEPTH = 16,
  parameter int          MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash,
  input  logic [31:0] redirect_pc,
  input  logic        ib_pop,
  input  logic [3:0]  Imem2proc_transaction_tag,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_data_tag,
  output logic [1:0]  proc2Imem_command,
  output logic [31:0] proc2Imem_addr,
  output IF_IB_PACKET if_ib_packet [0:1]
);

  localparam int CRW = $clog2(IB_DEPTH + 1);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CRW-1:0]     credit_q, credit_d;
  IF_IB_PACKET        pkt_q [0:1];
  IF_IB_PACKET        pkt_d [0:1];
  FETCH_PENDING_ENTRY head;
  FETCH_PENDING_ENTRY push_entry;
  logic               q_full, q_empty;
  logic               issue, accept, resp;
  logic [31:0]        aligned_pc;

  assign aligned_pc = {fetch_pc_q[31:3], 3'b000};
  assign issue  = !reset && !squash && (credit_q != '0) && !q_full;
  assign accept = issue && (Imem2proc_transaction_tag != '0);
  assign resp   = (Imem2proc_data_tag != '0) && !q_empty
                  && (Imem2proc_data_tag == head.tag);

  assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = issue ? aligned_pc : '0;
  assign if_ib_packet[0]   = pkt_q[0];
  assign if_ib_packet[1]   = pkt_q[1];

  assign push_entry = '{tag: Imem2proc_transaction_tag,
                        pc: fetch_pc_q, stale: 1'b0};

  fetch_pending_q #(.DEPTH(MAX_OUT)) u_q (
    .clock            (clock),
    .reset            (reset),
    .push_i           (accept),
    .push_entry_i     (push_entry),
    .pop_i            (resp),
    .mark_all_stale_i (squash),
    .head_o           (head),
    .full_o           (q_full),
    .empty_o          (q_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    credit_d   = credit_q;
    pkt_d[0]   = '0;
    pkt_d[1]   = '0;
    if (squash) begin
      fetch_pc_d = redirect_pc;
      credit_d   = CRW'(IB_DEPTH);
    end else begin
      if (accept) fetch_pc_d = aligned_pc + 32'd8;
      case ({accept, ib_pop})
        2'b10:   credit_d = credit_q - CRW'(1);
        2'b01:   credit_d = (credit_q == CRW'(IB_DEPTH)) ?
                            credit_q : credit_q + CRW'(1);
        default: credit_d = credit_q;
      endcase
      // A half-row fetch (pc[2]=1) uses only the upper word
      if (resp && !head.stale) begin
        pkt_d[0].valid = 1'b1;
        pkt_d[0].PC    = head.pc;
        pkt_d[0].NPC   = head.pc + 32'd4;
        if (!head.pc[2]) begin
          pkt_d[0].inst  = Imem2proc_data[31:0];
          pkt_d[1].valid = 1'b1;
          pkt_d[1].inst  = Imem2proc_data[63:32];
          pkt_d[1].PC    = head.pc + 32'd4;
          pkt_d[1].NPC   = head.pc + 32'd8;
        end else begin
          pkt_d[0].inst  = Imem2proc_data[63:32];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      credit_q   <= CRW'(IB_DEPTH);
      pkt_q[0]   <= '0;
      pkt_q[1]   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      credit_q   <= credit_d;
      pkt_q[0]   <= pkt_d[0];
      pkt_q[1]   <= pkt_d[1];
    end
  end

endmodule

// File: tb/tb_ib_fetch_ctrl.sv
// Directed bench for ib_fetch_ctrl with a 4-row buffer and
// a hand-sequenced instruction memory.
import sys_defs::*;

module tb_ib_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [31:0] redirect_pc;
  logic        ib_pop;
  logic [3:0]  tag_in;
  logic [63:0] dat;
  logic [3:0]  dtag;
  logic [1:0]  cmd;
  logic [31:0] addr;
  IF_IB_PACKET pkt [0:1];

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  ib_fetch_ctrl #(
    .IB_DEPTH (4),
    .MAX_OUT  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .squash                    (squash),
    .redirect_pc               (redirect_pc),
    .ib_pop                    (ib_pop),
    .Imem2proc_transaction_tag (tag_in),
    .Imem2proc_data            (dat),
    .Imem2proc_data_tag        (dtag),
    .proc2Imem_command         (cmd),
    .proc2Imem_addr            (addr),
    .if_ib_packet              (pkt)
  );

  task automatic chk(input string t, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] a);
    return {32'hB000_0000 + a, 32'hA000_0000 + a};
  endfunction

  task automatic drv(input logic [3:0] t, input logic [3:0] dt,
                     input logic [63:0] d, input logic p,
                     input logic s, input logic [31:0] rpc);
    tag_in      = t;
    dtag        = dt;
    dat         = d;
    ib_pop      = p;
    squash      = s;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv(4'd0, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    // reset state
    reset = 1'b1;
    drv(4'd5, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    tick();
    chk("rst_cmd", cmd, BUS_NONE);
    chk("rst_addr", addr, 32'd0);
    chk("rst_v0", pkt[0], '0);
    chk("rst_v1", pkt[1], '0);

    // free-running, 2-cycle memory latency, consumer pops every row
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drv((c < 10) ? 4'(c + 1) : 4'd0,
          (c >= 2 && c < 12) ? 4'(c - 1) : 4'd0,
          mk(32'(8 * (c - 2))),
          (c >= 3), 1'b0, 32'd0);
      if (c < 10) begin
        chk("fr_cmd", cmd, BUS_LOAD);
        chk("fr_addr", addr, 32'(8 * c));
      end
      if (c == 2) chk("fr_fill", pkt[0].valid, 1'b0);
      if (c >= 3) begin
        r = 32'(8 * (c - 3));
        chk("fr_v0", pkt[0].valid, 1'b1);
        chk("fr_pc0", pkt[0].PC, r);
        chk("fr_npc0", pkt[0].NPC, r + 32'd4);
        chk("fr_in0", pkt[0].inst, 32'hA000_0000 + r);
        chk("fr_v1", pkt[1].valid, 1'b1);
        chk("fr_pc1", pkt[1].PC, r + 32'd4);
        chk("fr_npc1", pkt[1].NPC, r + 32'd8);
        chk("fr_in1", pkt[1].inst, 32'hB000_0000 + r);
      end
      tick();
    end

    // credit exhaustion at depth 4
    do_reset();
    for (int c = 0; c < 11; c++) begin
      drv(4'(c + 1), (c >= 2 && c < 6) ? 4'(c - 1) : 4'd0,
          mk(32'(8 * (c - 2))), (c == 8), 1'b0, 32'd0);
      if (c < 4) begin
        chk("cr_cmd", cmd, BUS_LOAD);
        chk("cr_addr", addr, 32'(8 * c));
      end else if (c == 9) begin
        chk("cr_pop_cmd", cmd, BUS_LOAD);
        chk("cr_pop_addr", addr, 32'h20);
      end else begin
        chk("cr_none", cmd, BUS_NONE);
      end
      if (c == 5) chk("cr_none_addr", addr, 32'd0);
      tick();
    end

    // rejection: hold 0x20 for 3 cycles
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drv((c >= 4 && c <= 6) ? 4'd0 : 4'(c + 1),
          (c >= 1 && c <= 4) ? 4'(c) : 4'd0,
          mk(32'(8 * (c - 1))), (c <= 3), 1'b0, 32'd0);
      if (c >= 4 && c <= 7) begin
        chk("rj_cmd", cmd, BUS_LOAD);
        chk("rj_addr", addr, 32'h20);
      end
      if (c == 6) chk("rj_credit", dut.credit_q, 3'd4);
      if (c == 8) begin
        chk("rj_next", addr, 32'h28);
        chk("rj_credit2", dut.credit_q, 3'd3);
      end
      tick();
    end

    // squash with 3 outstanding, redirect 0x104
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drv(4'(c + 1), 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    drv(4'd5, 4'd0, 64'd0, 1'b0, 1'b1, 32'h104);
    chk("sq_cmd", cmd, BUS_NONE);
    tick();
    drv(4'd12, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    chk("sq_rs_cmd", cmd, BUS_LOAD);
    chk("sq_rs_addr", addr, 32'h100);
    tick();
    drv(4'd0, 4'd1, mk(32'h0), 1'b0, 1'b0, 32'd0);
    chk("sq_full", cmd, BUS_NONE);
    chk("sq_credit", dut.credit_q, 3'd3);
    tick();
    drv(4'd0, 4'd2, mk(32'h8), 1'b0, 1'b0, 32'd0);
    chk("sq_drop1", pkt[0].valid, 1'b0);
    tick();
    drv(4'd0, 4'd3, mk(32'h10), 1'b0, 1'b0, 32'd0);
    chk("sq_drop2", pkt[0].valid, 1'b0);
    tick();
    drv(4'd0, 4'd12, mk(32'h100), 1'b0, 1'b0, 32'd0);
    chk("sq_drop3", pkt[0].valid, 1'b0);
    tick();
    drv(4'd0, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    chk("sq_v0", pkt[0].valid, 1'b1);
    chk("sq_pc0", pkt[0].PC, 32'h104);
    chk("sq_npc0", pkt[0].NPC, 32'h108);
    chk("sq_in0", pkt[0].inst, 32'hB000_0100);
    chk("sq_v1", pkt[1].valid, 1'b0);
    tick();

    // ib_pop with accept leaves credit unchanged
    do_reset();
    drv(4'd1, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    tick();
    drv(4'd2, 4'd0, 64'd0, 1'b1, 1'b0, 32'd0);
    chk("pa_credit1", dut.credit_q, 3'd3);
    tick();
    drv(4'd0, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    chk("pa_credit2", dut.credit_q, 3'd3);
    tick();

    // squash together with a matching response
    do_reset();
    drv(4'd7, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    tick();
    drv(4'd0, 4'd7, mk(32'h0), 1'b0, 1'b1, 32'h40);
    chk("sr_cmd", cmd, BUS_NONE);
    tick();
    drv(4'd0, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    chk("sr_v0", pkt[0].valid, 1'b0);
    chk("sr_cnt", dut.u_q.count_q, 3'd0);
    chk("sr_addr", addr, 32'h40);
    tick();

    // spurious data tag is ignored
    do_reset();
    drv(4'd3, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    tick();
    drv(4'd0, 4'd9, mk(32'h0), 1'b0, 1'b0, 32'd0);
    tick();
    drv(4'd0, 4'd3, mk(32'h0), 1'b0, 1'b0, 32'd0);
    chk("sp_v0", pkt[0].valid, 1'b0);
    chk("sp_cnt", dut.u_q.count_q, 3'd1);
    tick();
    drv(4'd0, 4'd0, 64'd0, 1'b0, 1'b0, 32'd0);
    chk("sp_hit_v0", pkt[0].valid, 1'b1);
    chk("sp_hit_pc", pkt[0].PC, 32'h0);
    chk("sp_hit_in", pkt[0].inst, 32'hA000_0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ib_fetch_ctrl.md
# ib_fetch_ctrl

Fetch sequencer that feeds `inst_buffer`. It issues 64-bit instruction-memory loads, tracks outstanding transaction tags, and writes two-instruction rows into the buffer. A credit counter keeps in-flight plus buffered rows within the buffer depth, and a stale-marking scheme absorbs squashes and redirects. It sits between the instruction-memory port and the `if_ib_packet` input of `inst_buffer`.

## Interface
- `IB_DEPTH`, 16, row count of the downstream instruction buffer; initial credit value.
- `MAX_OUT`, 4, maximum outstanding memory transactions; depth of the pending queue.
- `RESET_PC`, 32'h0, fetch PC after reset.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `squash`  in  1  pipeline flush; fetch restarts at `redirect_pc`.
- `redirect_pc`  in  32  restart address, valid when `squash`=1.
- `ib_pop`  in  1  one-cycle pulse each time the buffer retires a full row (second half read).
- `Imem2proc_transaction_tag`  in  4  tag for this cycle's request; 0 means rejected.
- `Imem2proc_data`  in  64  returned block.
- `Imem2proc_data_tag`  in  4  tag of the returned block; 0 means no data.
- `proc2Imem_command`  out  2  BUS_LOAD or BUS_NONE.
- `proc2Imem_addr`  out  32  8-byte-aligned request address.
- `if_ib_packet[0:1]`  out  IF_IB_PACKET  row to the buffer. Slot 0 valid acts as the write strobe.

## Operation
- **State registers**
  - `fetch_pc`.
  - `credit`, range 0..IB_DEPTH.
  - Pending queue of MAX_OUT entries, each {tag, pc, stale}, with head/tail/count.
  - Registered output packet.
- **Issue condition:** `!reset && !squash && credit>0 && count<MAX_OUT`.
  - When true, drive BUS_LOAD with `proc2Imem_addr = {fetch_pc[31:3],3'b0}`. Otherwise drive BUS_NONE with addr 0.
- **Accept:** issue with a nonzero returned tag.
  - Push {tag, fetch_pc, stale=0}.
  - `credit--`.
  - `fetch_pc <= {fetch_pc[31:3],3'b0} + 8`.
- **Reject:** tag 0. No state change; the same address retries next cycle.
- **Response:** `Imem2proc_data_tag != 0` and equal to the head tag with count>0. The head is popped.
  - If the head is stale, the data is dropped.
  - Otherwise, with aligned pc (pc[2]=0):
    - slot0 = {valid=1, inst=data[31:0], PC=pc, NPC=pc+4}.
    - slot1 = {valid=1, inst=data[63:32], PC=pc+4, NPC=pc+8}.
  - Otherwise, with pc[2]=1:
    - slot0 = {valid=1, inst=data[63:32], PC=pc, NPC=pc+4}.
    - slot1 valid=0.
  - A nonzero data tag that does not match the head, or arrives with an empty queue, is ignored.
- **`ib_pop`:** `credit++`, saturating at IB_DEPTH.
  - Accept and pop in the same cycle leave the credit unchanged.
- **Squash**, which has priority over accept, pop and response write:
  - Every queue entry's stale bit is set. Entries stay queued so their tags drain.
  - `credit <= IB_DEPTH`.
  - `fetch_pc <= redirect_pc`.
  - Output packet valid bits are cleared.
  - A response arriving in the squash cycle still pops the head and is dropped.
- **Credit accounting:** stale responses never consumed buffer space, so credit needs no correction when they drain.

## Timing
- **Reset values:**
  - `fetch_pc = RESET_PC`, `credit = IB_DEPTH`, queue empty.
  - `proc2Imem_command = BUS_NONE`, `proc2Imem_addr = 0`.
  - `if_ib_packet` all zero (both valid=0).
- The request is combinational from registered state. The transaction tag is sampled in the same cycle.
- Response to packet latency is 1 cycle: the data tag is seen at edge N, and `if_ib_packet` is valid for exactly the cycle after edge N. It deasserts the following cycle unless another response arrives.
- **Back-to-back responses:** one row per cycle, with no bubble.
- **After squash:** issue resumes the cycle after the squash edge, from the aligned `redirect_pc`.
- **Reset mid-operation:** the queue is flushed. Responses that arrive later with old tags find the queue empty and are ignored.
- **Credit 0 or queue full:** BUS_NONE until `ib_pop` or a response frees room. A freed resource is usable in the next cycle, not the same one.

## Structure
- `sys_defs` package holds:
  - IF_IB_PACKET {valid, inst, NPC, PC}.
  - BUS_LOAD/BUS_NONE encodings.
  - The 4-bit MEM_TAG type.
  - A new FETCH_PENDING_ENTRY {tag, pc, stale} typedef.
- One sub-module: `fetch_pending_q`, a MAX_OUT-entry circular queue.
  - Ports: push, pop, head read, and a mark_all_stale input.

## Test plan
- **Reset then free-running:** reset, memory accepts every request with rotating tags 1..15 and returns data 2 cycles later. Required: addr 0x0, 0x8, 0x10, …; rows carry PC/NPC 0/4, 4/8, 8/C, …; no bubble after the pipeline fills.
- **Credit exhaustion:** IB_DEPTH=4, no `ib_pop`. Required: exactly 4 accepted requests, then BUS_NONE. One `ib_pop` pulse allows exactly one more request, starting the next cycle.
- **Rejection:** tag 0 for 3 cycles at addr 0x20. Required: addr 0x20 is held all 3 cycles, credit is unchanged, and 0x20 is accepted on the 4th cycle.
- **Squash with 3 outstanding:** squash to `redirect_pc` 0x104 while 3 requests are outstanding. Required: 3 old responses produce no packet. The first post-squash request uses addr 0x100. Its row has slot0 PC=0x104 with inst=data[63:32], and slot1 valid=0.
- **Same-cycle events:**
  - `ib_pop` together with an accept leaves credit unchanged.
  - squash together with a matching response: the head is popped and no packet is produced.
- **Spurious tag:** a response with a data tag not at the head. Required: no packet, and the queue is unchanged.
